vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the 640x480 VGA timing generator. Samples active-low hs/vs/blank
//  and reconstructs pixel coordinates (X,Y), data-enable and line/frame strobes. Measures
//  line/frame geometry and runs a lock FSM. Feeds capture/overlay and frame-check logic.
// PARAMETERS
//  H_TOTAL      800  expected pixels per line (hs-fall to hs-fall)
//  V_TOTAL      525  expected lines per frame (hs falls between vs falls)
//  H_ACTIVE     640  expected blank=1 pixels per active line
//  V_ACTIVE     480  expected active lines per frame
//  LOCK_FRAMES  2    consecutive matching frames needed to assert Locked (1..7)
// PORTS
//  Clk        in   1   system clock, 50 MHz
//  Reset      in   1   asynchronous, active-high
//  PixEn      in   1   pixel-rate strobe, one Clk wide (every 2nd Clk at 25 MHz)
//  hs_n       in   1   horizontal sync, active low
//  vs_n       in   1   vertical sync, active low
//  blank_n    in   1   1 = active video, 0 = blanking
//  X          out  10  pixel index within active line, 0..H_ACTIVE-1
//  Y          out  10  active line index, 0..V_ACTIVE-1
//  DE         out  1   registered blank_n (aligned with X/Y)
//  LineStart  out  1   one-Clk pulse: first active pixel of a line
//  FrameStart out  1   one-Clk pulse: vs falling edge detected
//  Locked     out  1   geometry matched for LOCK_FRAMES consecutive frames
//  TimingErr  out  1   one-Clk pulse: mismatch or watchdog while LOCKED
//  HTotal     out  10  last measured line length, pixels
//  VTotal     out  10  last measured frame length, lines
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, FSM SEARCH, match count 0, previous-sample regs = 1.
//  - Only samples with PixEn=1 advance state; otherwise all regs hold and pulses drop to 0.
//  - Edge detect per input vs previous PixEn sample: fall = prev 1 and now 0; rise = prev 0 and now 1.
//  - Outputs registered: an input sample at PixEn edge k is reflected on outputs after that edge
//    (latency 1 Clk from the sampling edge).
//  - h_cnt: 0 on hs fall, else +1, saturating at 1023. On hs fall, HTotal <= h_cnt+1.
//  - l_cnt: +1 on each hs fall. On vs fall, VTotal <= l_cnt (including an hs fall in the same
//    sample, i.e. l_cnt+1), then l_cnt <= 0.
//  - X: 0 on blank rise (LineStart=1), +1 per active sample. Holds during blanking.
//  - a_cnt: counts blank_n=1 samples. On blank fall, compare with H_ACTIVE; set sticky
//    frame_bad if unequal. Y is cleared on vs fall and +1 on each blank fall, saturating at 1023.
//  - Frame check on vs fall: good = (VTotal_new==V_TOTAL)&&(HTotal==H_TOTAL)&&(Y==V_ACTIVE)
//    &&!frame_bad. Then clear frame_bad.
//  - FSM:
//    SEARCH -> TRAIN on first vs fall (no frame check).
//    TRAIN: on vs fall, good -> cnt+1; if cnt+1==LOCK_FRAMES go LOCKED (Locked=1);
//           !good -> cnt=0, stay in TRAIN.
//    LOCKED: on vs fall, !good -> SEARCH, cnt=0, Locked=0, TimingErr pulse.
//  - Watchdog: h_cnt reaching 1023 in any state -> SEARCH, Locked=0, cnt=0.
//    TimingErr pulses only if the FSM was LOCKED.
//  - Simultaneous vs fall and hs fall: both apply in the same sample; VTotal counts that hs fall.
//  - Simultaneous blank fall and vs fall: Y increments first, then the frame check uses the
//    incremented Y, then Y clears.
//  - Reset mid-frame: immediate return to reset state; relock needs 1+LOCK_FRAMES vs falls.
// STRUCTURE
//  - Package vga_timing_pkg:
//    - localparams H_TOTAL/V_TOTAL/H_ACTIVE/V_ACTIVE defaults;
//    - typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} sync_state_t.
//  - Sub-module sync_edge_det (Clk, Reset, PixEn, d -> q, fall, rise):
//    - instantiated 3x (hs, vs, blank); previous-sample regs reset to 1.
//  - Top holds the counters, the frame-check compare and the FSM.
// TESTING
//  - Nominal 800x525 timing from the bench sync model (PixEn every 2nd Clk):
//    - Locked rises at the 3rd vs fall (LOCK_FRAMES=2); HTotal=800, VTotal=525;
//    - X runs 0..639, Y runs 0..479; exactly 480 LineStart pulses per frame.
//  - After lock, one line stretched to 801 pixels:
//    - TimingErr pulses once at the next vs fall; Locked=0; relock after 3 more vs falls.
//  - hs held high for 1100 pixels while LOCKED:
//    - watchdog fires at h_cnt=1023; Locked=0; TimingErr=1 for one Clk.
//  - PixEn held 0 for 50 Clk mid-line: X, Y, HTotal unchanged; no pulses.
//  - Reset asserted at line 200 while LOCKED:
//    - all outputs 0 on the same Clk; Locked returns only after the 3rd vs fall post-release.
//  - Active width 639 on one line during TRAIN: cnt=0 at vs fall; Locked stays 0 that frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and lock-state encoding for the VGA receive path.
// Holds the nominal 640x480@60 geometry defaults used by vga_sync_decoder
// and the state type of its lock FSM.
// Ports: none (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int          CNT_W   = 10;
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Pixel-rate edge detector for one active-low sync/blank input. Keeps the
// previous pixel sample and flags falling/rising transitions of the current
// sample against it.
// Ports:
//   Clk    in  system clock
//   Reset  in  asynchronous, active-high; previous sample resets to 1
//   PixEn  in  pixel-rate strobe; previous sample only updates when high
//   d      in  current input level
//   q      out previous pixel sample
//   fall   out q=1 and d=0 (valid for the current PixEn sample)
//   rise   out q=0 and d=1 (valid for the current PixEn sample)
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic PixEn,
  input  logic d,
  output logic q,
  output logic fall,
  output logic rise
);

  // Previous sample idles high so a line/frame already in sync is seen as an
  // edge on the first sample after reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= 1'b1;
    end else if (PixEn) begin
      q <= d;
    end
  end

  assign fall = q & ~d;
  assign rise = ~q & d;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing recovery. Samples hs_n/vs_n/blank_n at pixel rate,
// rebuilds active-area coordinates and strobes, measures line and frame
// length, and qualifies the incoming geometry with a SEARCH/TRAIN/LOCKED FSM.
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   PixEn               pixel-rate strobe (one Clk wide)
//   hs_n, vs_n          active-low syncs
//   blank_n             1 = active video
//   X, Y [9:0]          active pixel / active line index
//   DE                  registered blank_n, aligned with X/Y
//   LineStart           pulse on first active pixel of a line
//   FrameStart          pulse on vs falling edge
//   Locked              geometry matched LOCK_FRAMES frames in a row
//   TimingErr           pulse on mismatch or watchdog while locked
//   HTotal, VTotal[9:0] last measured line length (pixels) / frame (lines)
// ---------------------------------------------------------------------------
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PixEn,
  input  logic       hs_n,
  input  logic       vs_n,
  input  logic       blank_n,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       DE,
  output logic       LineStart,
  output logic       FrameStart,
  output logic       Locked,
  output logic       TimingErr,
  output logic [9:0] HTotal,
  output logic [9:0] VTotal
);

  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [2:0] LOCK_C     = 3'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // Edge detection against the previous pixel sample
  logic hs_fall, vs_fall, blank_fall, blank_rise;
  logic hs_prev_unused, vs_prev_unused, blank_prev_unused;
  logic hs_rise_unused, vs_rise_unused;

  sync_edge_det u_hs_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .PixEn (PixEn),
    .d     (hs_n),
    .q     (hs_prev_unused),
    .fall  (hs_fall),
    .rise  (hs_rise_unused)
  );

  sync_edge_det u_vs_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .PixEn (PixEn),
    .d     (vs_n),
    .q     (vs_prev_unused),
    .fall  (vs_fall),
    .rise  (vs_rise_unused)
  );

  sync_edge_det u_blank_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .PixEn (PixEn),
    .d     (blank_n),
    .q     (blank_prev_unused),
    .fall  (blank_fall),
    .rise  (blank_rise)
  );

  logic [9:0]  h_cnt, l_cnt, a_cnt;
  logic [2:0]  match_cnt;
  logic        frame_bad;
  sync_state_t state;

  // Next-sample values; a vs fall that coincides with an hs fall or a blank
  // fall must see the counts that include those edges.
  logic [9:0] h_cnt_nxt, htotal_nxt, l_cnt_inc, y_inc;
  logic       bad_now, good, watchdog;

  always_comb begin
    h_cnt_nxt  = hs_fall ? 10'd0 : sat_inc(h_cnt);
    htotal_nxt = hs_fall ? (h_cnt + 10'd1) : HTotal;
    l_cnt_inc  = hs_fall ? sat_inc(l_cnt) : l_cnt;
    y_inc      = blank_fall ? sat_inc(Y) : Y;
    bad_now    = frame_bad | (blank_fall & (a_cnt != H_ACTIVE_C));
    good       = (l_cnt_inc == V_TOTAL_C) && (htotal_nxt == H_TOTAL_C) &&
                 (y_inc == V_ACTIVE_C) && !bad_now;
    // A line that never sees hs fall again pins h_cnt at its ceiling.
    watchdog   = (h_cnt_nxt == CNT_MAX);
  end

  // Registered outputs, counters and lock FSM (one stage after the sample)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      X          <= '0;
      Y          <= '0;
      DE         <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      Locked     <= 1'b0;
      TimingErr  <= 1'b0;
      HTotal     <= '0;
      VTotal     <= '0;
      h_cnt      <= '0;
      l_cnt      <= '0;
      a_cnt      <= '0;
      match_cnt  <= '0;
      frame_bad  <= 1'b0;
      state      <= SEARCH;
    end else begin
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      TimingErr  <= 1'b0;
      if (PixEn) begin
        h_cnt      <= h_cnt_nxt;
        HTotal     <= htotal_nxt;
        l_cnt      <= l_cnt_inc;
        DE         <= blank_n;
        LineStart  <= blank_rise;
        FrameStart <= vs_fall;
        frame_bad  <= bad_now;
        Y          <= y_inc;

        if (blank_rise) begin
          X     <= '0;
          a_cnt <= 10'd1;
        end else if (blank_n) begin
          X     <= X + 10'd1;
          a_cnt <= sat_inc(a_cnt);
        end

        if (vs_fall) begin
          VTotal    <= l_cnt_inc;
          l_cnt     <= '0;
          Y         <= '0;
          frame_bad <= 1'b0;
          case (state)
            SEARCH: begin
              state     <= TRAIN;
              match_cnt <= '0;
            end
            TRAIN: begin
              if (good) begin
                match_cnt <= match_cnt + 3'd1;
                if (match_cnt + 3'd1 == LOCK_C) begin
                  state  <= LOCKED;
                  Locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!good) begin
                state     <= SEARCH;
                match_cnt <= '0;
                Locked    <= 1'b0;
                TimingErr <= 1'b1;
              end
            end
            default: begin
              state     <= SEARCH;
              match_cnt <= '0;
              Locked    <= 1'b0;
            end
          endcase
        end

        // Watchdog overrides any frame-boundary decision in the same sample.
        if (watchdog) begin
          if (state == LOCKED) begin
            TimingErr <= 1'b1;
          end
          state     <= SEARCH;
          match_cnt <= '0;
          Locked    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Bench for vga_sync_decoder on a scaled-down raster (40x12 total, 24x8
// active) so several full frames fit in a short run. A sample-level
// reference model predicts every output; directed frames exercise lock,
// stretched lines, watchdog, PixEn gaps, mid-frame reset and a short line.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT = 40, VT = 12, HA = 24, VA = 8, LF = 2;
  localparam int HS_W = 4, H_ACT0 = 8, VS_W = 2, V_ACT0 = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       PixEn = 1'b0;
  logic       hs_n = 1'b1, vs_n = 1'b1, blank_n = 1'b1;
  logic [9:0] X, Y, HTotal, VTotal;
  logic       DE, LineStart, FrameStart, Locked, TimingErr;

  always #5 Clk = ~Clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PixEn(PixEn),
    .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n),
    .X(X), .Y(Y), .DE(DE), .LineStart(LineStart), .FrameStart(FrameStart),
    .Locked(Locked), .TimingErr(TimingErr), .HTotal(HTotal), .VTotal(VTotal)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      if (fails >= 200) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  // ---------------- reference model (per pixel sample) ----------------
  int m_pix, m_lines, m_x, m_act, m_y, m_run;
  bit m_bad, m_armed, m_locked;
  bit p_hs, p_vs, p_bl;
  int e_x, e_y, e_de, e_ls, e_fs, e_lk, e_te, e_ht, e_vt;

  function automatic int clamp(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_reset();
    m_pix = 0; m_lines = 0; m_x = 0; m_act = 0; m_y = 0; m_run = 0;
    m_bad = 0; m_armed = 0; m_locked = 0;
    p_hs = 1; p_vs = 1; p_bl = 1;
    e_x = 0; e_y = 0; e_de = 0; e_ls = 0; e_fs = 0; e_lk = 0; e_te = 0; e_ht = 0; e_vt = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit bl);
    bit hf, vf, br, bf, wd, good, was_locked;
    hf = p_hs && !hs; vf = p_vs && !vs; br = !p_bl && bl; bf = p_bl && !bl;
    p_hs = hs; p_vs = vs; p_bl = bl;
    was_locked = m_locked;
    e_de = bl; e_ls = br; e_fs = vf;
    if (hf) begin
      e_ht = (clamp(m_pix) + 1) % 1024;
      m_pix = 0;
      m_lines++;
    end else begin
      m_pix++;
    end
    wd = (clamp(m_pix) == 1023);
    if (br) m_x = 0; else if (bl) m_x = (m_x + 1) % 1024;
    e_x = m_x;
    if (br) m_act = 1; else if (bl) m_act++;
    if (bf && m_act != HA) m_bad = 1;
    if (bf) m_y++;
    e_y = clamp(m_y);
    if (vf) begin
      good = (clamp(m_lines) == VT) && (e_ht == HT) && (clamp(m_y) == VA) && !m_bad;
      e_vt = clamp(m_lines);
      m_lines = 0; m_y = 0; e_y = 0; m_bad = 0;
      if (!m_armed) begin
        m_armed = 1; m_run = 0;
      end else if (!m_locked) begin
        if (good) begin
          m_run++;
          if (m_run == LF) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end else if (!good) begin
        m_armed = 0; m_locked = 0; m_run = 0; e_te = 1;
      end
    end
    if (wd) begin
      if (was_locked) e_te = 1;
      m_armed = 0; m_locked = 0; m_run = 0;
    end
    e_lk = m_locked;
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      model_reset();
    end else begin
      e_ls = 0; e_fs = 0; e_te = 0;
      if (PixEn) model_step(hs_n, vs_n, blank_n);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  int ls_cnt = 0, te_cnt = 0, fs_cnt = 0;
  int x_max = 0, y_max = 0;

  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      check("cyc_X", X, e_x);
      check("cyc_Y", Y, e_y);
      check("cyc_DE", DE, e_de);
      check("cyc_LineStart", LineStart, e_ls);
      check("cyc_FrameStart", FrameStart, e_fs);
      check("cyc_Locked", Locked, e_lk);
      check("cyc_TimingErr", TimingErr, e_te);
      check("cyc_HTotal", HTotal, e_ht);
      check("cyc_VTotal", VTotal, e_vt);
    end
    if (LineStart === 1'b1) ls_cnt++;
    if (TimingErr === 1'b1) te_cnt++;
    if (FrameStart === 1'b1) fs_cnt++;
    if (DE === 1'b1) begin
      if (int'(X) > x_max) x_max = int'(X);
      if (int'(Y) > y_max) y_max = int'(Y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pix(input bit hs, input bit vs, input bit bl);
    @(negedge Clk);
    hs_n = hs; vs_n = vs; blank_n = bl; PixEn = 1'b1;
    @(negedge Clk);
    PixEn = 1'b0;
  endtask

  task automatic pause_check(input int v);
    int ls0, te0, fs0;
    ls0 = ls_cnt; te0 = te_cnt; fs0 = fs_cnt;
    repeat (50) @(negedge Clk);
    check("pause_X", X, H_ACT0 == 8 ? 7 : 0);
    check("pause_Y", Y, v - V_ACT0);
    check("pause_HTotal", HTotal, HT);
    check("pause_pulses", (ls_cnt - ls0) + (te_cnt - te0) + (fs_cnt - fs0), 0);
  endtask

  task automatic frame(input int start_v, input int abort_v, input int stretch,
                       input int narrow_v, input int wd_v, input int pause_v);
    int len, a_end;
    bit act;
    for (int v = start_v; v < VT; v++) begin
      len = HT;
      if (v == VT - 1) len = len + stretch;
      if (v == wd_v) len = len + 1100;
      a_end = H_ACT0 + HA - ((v == narrow_v) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        if (v == abort_v && h == 10) return;
        if (v == pause_v && h == 16) pause_check(v);
        act = (v >= V_ACT0) && (v < V_ACT0 + VA) && (h >= H_ACT0) && (h < a_end);
        pix(h >= HS_W, v >= VS_W, act);
      end
    end
  endtask

  task automatic nominal();
    frame(0, -1, 0, -1, -1, -1);
  endtask

  task automatic pulse_reset(input string tag, input bit verify);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    if (verify) begin
      check({tag, "_X"}, X, 0);
      check({tag, "_Y"}, Y, 0);
      check({tag, "_DE"}, DE, 0);
      check({tag, "_LineStart"}, LineStart, 0);
      check({tag, "_FrameStart"}, FrameStart, 0);
      check({tag, "_Locked"}, Locked, 0);
      check({tag, "_TimingErr"}, TimingErr, 0);
      check({tag, "_HTotal"}, HTotal, 0);
      check({tag, "_VTotal"}, VTotal, 0);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int ls0, te0;
    // Power-up reset state
    repeat (3) @(negedge Clk);
    check("reset_X", X, 0);
    check("reset_Y", Y, 0);
    check("reset_DE", DE, 0);
    check("reset_Locked", Locked, 0);
    check("reset_TimingErr", TimingErr, 0);
    check("reset_HTotal", HTotal, 0);
    check("reset_VTotal", VTotal, 0);
    Reset = 1'b0;
    chk_en = 1'b1;

    // Nominal lock: third vs fall locks
    nominal();
    nominal();
    check("lock_after_2nd_vs", Locked, 0);
    ls0 = ls_cnt; x_max = 0; y_max = 0;
    nominal();
    check("lock_after_3rd_vs", Locked, 1);
    check("nom_HTotal", HTotal, HT);
    check("nom_VTotal", VTotal, VT);
    check("nom_linestarts", ls_cnt - ls0, VA);
    check("nom_x_max", x_max, HA - 1);
    check("nom_y_max", y_max, VA - 1);

    // PixEn gap mid-line
    frame(0, -1, 0, -1, -1, 4);
    check("pause_still_locked", Locked, 1);

    // Last line of a frame stretched by one pixel
    te0 = te_cnt;
    frame(0, -1, 1, -1, -1, -1);
    nominal();
    check("stretch_te_pulses", te_cnt - te0, 1);
    check("stretch_unlocked", Locked, 0);
    nominal();
    nominal();
    check("stretch_relock_pending", Locked, 0);
    nominal();
    check("stretch_relocked", Locked, 1);

    // hs stuck high for 1100 extra pixels while locked
    te0 = te_cnt;
    frame(0, -1, 0, -1, 5, -1);
    check("wd_te_cycles", te_cnt - te0, 1);
    check("wd_unlocked", Locked, 0);
    nominal();
    nominal();
    nominal();
    check("wd_relocked", Locked, 1);

    // Reset in the middle of line 5 while locked
    frame(0, 5, 0, -1, -1, -1);
    check("pre_reset_locked", Locked, 1);
    pulse_reset("midrst", 1'b1);
    frame(6, -1, 0, -1, -1, -1);
    nominal();
    nominal();
    check("midrst_after_2nd_vs", Locked, 0);
    nominal();
    check("midrst_after_3rd_vs", Locked, 1);

    // One short active line (HA-1) while training
    pulse_reset("narrow", 1'b0);
    nominal();
    frame(0, -1, 0, 4, -1, -1);
    nominal();
    check("narrow_no_lock_3rd_vs", Locked, 0);
    nominal();
    check("narrow_no_lock_4th_vs", Locked, 0);
    nominal();
    check("narrow_lock_5th_vs", Locked, 1);

    repeat (4) @(negedge Clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
